// File: rtl/sim_end_writer.sv
// End-of-test signaller on the DM1 write path: free-running cycle counter, and on a
// finish request writes the snapshot after the result block, then the SIM_END marker.
module sim_end_writer #(
    parameter int unsigned       ADDR_W       = 14,
    parameter logic [ADDR_W-1:0] TEST_START   = 'h2000,
    parameter logic [ADDR_W-1:0] SIM_END      = 'h3fff,
    parameter logic [31:0]       SIM_END_CODE = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              finish_valid,
    output logic              finish_ready,
    input  logic [ADDR_W-1:0] finish_count,
    output logic              dm_req,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    output logic              done,
    output logic [63:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_WR_END,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [63:0]       r_cycle;
    logic [63:0]       r_snap;
    logic [ADDR_W-1:0] r_base;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_ready;

    state_t            w_state_nxt;
    logic [63:0]       w_snap_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [ADDR_W-1:0] w_hi_addr;
    logic [ADDR_W-1:0] w_hi_addr_nxt;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_wdata_nxt;

    assign w_hi_addr     = r_base + ADDR_W'(1);
    assign w_hi_addr_nxt = w_base_nxt + ADDR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_base_nxt  = r_base;
        case (r_state)
            S_IDLE: begin
                if (finish_valid && r_ready) begin
                    w_state_nxt = S_WR_LO;
                    w_snap_nxt  = r_cycle;
                    w_base_nxt  = TEST_START + finish_count;
                end
            end
            S_WR_LO:  if (r_base == SIM_END || dm_gnt) w_state_nxt = S_WR_HI;
            S_WR_HI:  if (w_hi_addr == SIM_END || dm_gnt) w_state_nxt = S_WR_END;
            S_WR_END: if (dm_gnt) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge the
    // state does; a snapshot word landing on SIM_END yields a request-free cycle.
    always_comb begin
        w_req_nxt   = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        case (w_state_nxt)
            S_WR_LO: begin
                if (w_base_nxt != SIM_END) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_base_nxt;
                    w_wdata_nxt = w_snap_nxt[31:0];
                end
            end
            S_WR_HI: begin
                if (w_hi_addr_nxt != SIM_END) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_hi_addr_nxt;
                    w_wdata_nxt = w_snap_nxt[63:32];
                end
            end
            S_WR_END: begin
                w_req_nxt   = 1'b1;
                w_addr_nxt  = SIM_END;
                w_wdata_nxt = SIM_END_CODE;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_addr_nxt  = '0;
                w_wdata_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cycle <= '0;
            r_snap  <= '0;
            r_base  <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cycle <= r_cycle + 64'd1;
            r_snap  <= w_snap_nxt;
            r_base  <= w_base_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign finish_ready = r_ready;
    assign dm_req       = r_req;
    assign dm_addr      = r_addr;
    assign dm_wdata     = r_wdata;
    assign done         = r_done;
    assign cycle_count  = r_cycle;

endmodule

// File: tb/tb_sim_end_writer.sv
// Scoreboard bench for sim_end_writer: a posedge reference model pushes expected DM
// writes on accepted finishes; a negedge monitor pops and compares each granted write.
module tb_sim_end_writer;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          finish_valid = 1'b0;
    logic [AW-1:0] finish_count = '0;
    logic          dm_gnt = 1'b1;
    logic          finish_ready;
    logic          dm_req;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          done;
    logic [63:0]   cycle_count;

    sim_end_writer #(
        .ADDR_W      (14),
        .TEST_START  (14'h2000),
        .SIM_END     (14'h3fff),
        .SIM_END_CODE(32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .finish_valid(finish_valid),
        .finish_ready(finish_ready),
        .finish_count(finish_count),
        .dm_req      (dm_req),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_gnt      (dm_gnt),
        .done        (done),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        bit            is_end;
    } wr_t;

    wr_t               exp_q[$];
    longint unsigned   wlog_cyc[$];
    logic [AW-1:0]     wlog_addr[$];
    int                total = 0;
    int                bad = 0;
    longint unsigned   m_cycle = 0;
    bit                m_ready = 0, m_done = 0, m_accepted = 0, end_seen = 0, m_live = 0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Spec rules: LO at TEST_START+count, HI one above (mod 2^14), neither may land on SIM_END.
    function automatic void push_finish(input logic [AW-1:0] fc, input longint unsigned snap);
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        logic [63:0]   s;
        s  = snap;
        lo = 14'h2000 + fc;
        hi = lo + 14'd1;
        if (lo != 14'h3fff) exp_q.push_back('{addr: lo, data: s[31:0], is_end: 1'b0});
        if (hi != 14'h3fff) exp_q.push_back('{addr: hi, data: s[63:32], is_end: 1'b0});
        exp_q.push_back('{addr: 14'h3fff, data: 32'hFFFF_FFFF, is_end: 1'b1});
        m_accepted = 1;
    endfunction

    // Reference model: inputs change at posedge+1, so values read here are the sampled ones.
    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_cycle = 0; m_ready = 0; m_done = 0;
            m_accepted = 0; end_seen = 0;
            exp_q.delete();
        end else if (m_live) begin
            if (finish_valid && m_ready) push_finish(finish_count, m_cycle);
            if (end_seen) m_done = 1;
            m_cycle++;
            m_ready = !m_accepted;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (m_live) begin
            check64("cycle_count", cycle_count, m_cycle);
            check64("finish_ready", {63'd0, finish_ready}, {63'd0, m_ready});
            check64("done", {63'd0, done}, {63'd0, m_done});
            if (exp_q.size() == 0) check64("req_without_pending", {63'd0, dm_req}, 64'd0);
            if (dm_req === 1'b1 && exp_q.size() != 0) begin
                check64("wr_addr", {50'd0, dm_addr}, {50'd0, exp_q[0].addr});
                check64("wr_data", {32'd0, dm_wdata}, {32'd0, exp_q[0].data});
                if (dm_gnt) begin
                    e = exp_q.pop_front();
                    wlog_cyc.push_back(m_cycle);
                    wlog_addr.push_back(dm_addr);
                    if (e.is_end) end_seen = 1;
                end
            end else if (dm_req !== 1'b1) begin
                check64("idle_addr", {50'd0, dm_addr}, 64'd0);
                check64("idle_data", {32'd0, dm_wdata}, 64'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        finish_valid = 1'b0;
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] fc, output longint unsigned snap);
        int n = 0;
        while (!m_ready && n < 20) begin tick(); n++; end
        check64("ready_before_issue", {63'd0, finish_ready}, 64'd1);
        wlog_cyc.delete();
        wlog_addr.delete();
        finish_count = fc;
        finish_valid = 1'b1;
        snap = m_cycle;
        tick();
        finish_valid = 1'b0;
    endtask

    task automatic wait_done(input bit noisy);
        int n = 0;
        while (!m_done && n < 200) begin
            if (noisy) begin
                dm_gnt       = ($urandom % 10) < 7;
                finish_valid = ($urandom % 6) == 0;
                finish_count = AW'($urandom);
            end
            tick();
            n++;
        end
        finish_valid = 1'b0;
        check64("done_reached", {63'd0, done}, 64'd1);
    endtask

    task automatic chk_log(input string nm, input longint unsigned snap, input int n,
                           input int o0, input int o1, input int o2);
        int offs[3];
        offs = '{o0, o1, o2};
        check64({nm, "_nwrites"}, 64'(wlog_cyc.size()), 64'(n));
        for (int i = 0; i < n && i < wlog_cyc.size(); i++)
            check64({nm, "_wcycle"}, wlog_cyc[i], snap + 64'(offs[i]));
    endtask

    initial begin
        longint unsigned snap;
        int k;

        // reset: 3 cycles then free-running count
        dm_gnt = 1'b1;
        do_reset(3);
        check64("post_rst_count", cycle_count, 64'd0);
        check64("post_rst_req", {63'd0, dm_req}, 64'd0);
        repeat (4) tick();
        check64("count_4", cycle_count, 64'd4);

        // basic finish at count 100
        while (m_cycle < 100) tick();
        issue(14'd5, snap);
        check64("basic_snap", snap, 64'd100);
        wait_done(1'b0);
        chk_log("basic", snap, 3, 1, 2, 3);
        if (wlog_addr.size() == 3) begin
            check64("basic_a0", {50'd0, wlog_addr[0]}, 64'h2005);
            check64("basic_a1", {50'd0, wlog_addr[1]}, 64'h2006);
            check64("basic_a2", {50'd0, wlog_addr[2]}, 64'h3fff);
        end
        finish_valid = 1'b1;
        finish_count = 14'd3;
        repeat (2) tick();
        finish_valid = 1'b0;
        repeat (4) tick();
        check64("done_sticky", {63'd0, done}, 64'd1);
        check64("ignored_no_write", 64'(wlog_cyc.size()), 64'd3);

        // grant stall of 3 cycles in WR_HI
        do_reset(2);
        repeat (3) tick();
        issue(14'd5, snap);
        tick();
        dm_gnt = 1'b0;
        repeat (3) tick();
        dm_gnt = 1'b1;
        wait_done(1'b0);
        chk_log("stall", snap, 3, 1, 5, 6);

        // LO lands on SIM_END
        do_reset(1);
        repeat (2) tick();
        issue(14'h1fff, snap);
        wait_done(1'b0);
        chk_log("coll_lo", snap, 2, 2, 3, 0);
        if (wlog_addr.size() == 2) begin
            check64("coll_lo_a0", {50'd0, wlog_addr[0]}, 64'h0000);
            check64("coll_lo_a1", {50'd0, wlog_addr[1]}, 64'h3fff);
        end

        // HI lands on SIM_END
        do_reset(1);
        repeat (2) tick();
        issue(14'h1ffe, snap);
        wait_done(1'b0);
        chk_log("coll_hi", snap, 2, 1, 3, 0);
        if (wlog_addr.size() == 2) begin
            check64("coll_hi_a0", {50'd0, wlog_addr[0]}, 64'h3ffe);
            check64("coll_hi_a1", {50'd0, wlog_addr[1]}, 64'h3fff);
        end

        // reset while stalled in WR_HI, then a fresh finish
        do_reset(1);
        repeat (5) tick();
        issue(14'd9, snap);
        tick();
        dm_gnt = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check64("midrst_req", {63'd0, dm_req}, 64'd0);
        check64("midrst_done", {63'd0, done}, 64'd0);
        check64("midrst_count", cycle_count, 64'd0);
        dm_gnt = 1'b1;
        repeat (4) tick();
        issue(14'd7, snap);
        check64("midrst_snap", snap, 64'd4);
        wait_done(1'b0);
        chk_log("midrst", snap, 3, 1, 2, 3);

        // randomized finishes with random grants, noise requests and occasional resets
        for (int it = 0; it < 30; it++) begin
            do_reset($urandom_range(1, 3));
            repeat ($urandom_range(1, 6)) begin
                dm_gnt = ($urandom % 10) < 7;
                tick();
            end
            k = $urandom % 4;
            issue((k == 0) ? 14'h1fff : (k == 1) ? 14'h1ffe : AW'($urandom), snap);
            if (($urandom % 5) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    dm_gnt = ($urandom % 10) < 7;
                    tick();
                end
                do_reset(1);
                check64("rand_rst_req", {63'd0, dm_req}, 64'd0);
            end else begin
                wait_done(1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/sim_end_writer.md
# sim_end_writer

Memory-mapped end-of-test signaller that sits beside the core on the data-memory (DM1) write path. It counts cycles from reset release. When the program or control logic requests a finish, it writes the cycle count into DM just after the result block. It then writes the end-of-simulation code to the SIM_END word, which is the condition the top-level bench waits on before comparing DM[TEST_START…] against golden data.

## Interface
Parameters:
- ADDR_W, 14, DM word-address width (16384 words)
- TEST_START, 'h2000, word address of the first result word
- SIM_END, 'h3fff, word address of the end marker
- SIM_END_CODE, 32'hFFFF_FFFF, marker value (-1)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- finish_valid  in  1  finish request
- finish_ready  out  1  high only in IDLE
- finish_count  in  ADDR_W  number of result words already written (offset past TEST_START)
- dm_req  out  1  DM word-write request
- dm_addr  out  ADDR_W  DM word address
- dm_wdata  out  32  DM write data
- dm_gnt  in  1  DM arbiter grant; write occurs in a cycle with dm_req & dm_gnt
- done  out  1  sticky; end marker written
- cycle_count  out  64  free-running cycle counter

## Operation
- cycle_count: 0 in reset; +1 every non-reset cycle; wraps mod 2^64; keeps counting after done.
- FSM states: IDLE, WR_LO, WR_HI, WR_END, DONE.
- IDLE: finish_ready=1.
  - Accept on finish_valid & finish_ready.
  - Capture snap = cycle_count value of the accept cycle.
  - Capture base = (TEST_START + finish_count) mod 2^ADDR_W.
  - Go to WR_LO.
- WR_LO: address base, data snap[31:0].
- WR_HI: address (base+1) mod 2^ADDR_W, data snap[63:32].
- WR_END: address SIM_END, data SIM_END_CODE.
- Each write state asserts dm_req and advances on dm_gnt. dm_addr and dm_wdata are stable while dm_req & !dm_gnt.
- Collision rule: a WR_LO or WR_HI whose address equals SIM_END is skipped. In that case dm_req=0 for that state and the FSM moves to the next state in one cycle. The marker is only ever written by WR_END.
- WR_END granted -> DONE.
- DONE: done=1, dm_req=0, finish_ready=0. Held until rst.
- finish_valid outside IDLE is ignored, with no side effects.
- Outputs in reset and whenever dm_req=0: dm_req=0, dm_addr=0, dm_wdata=0, done=0, finish_ready=0 during the rst cycle (1 from the first post-reset cycle), cycle_count=0.

## Timing
- All outputs are registered; no combinational path from dm_gnt or finish_valid to any output.
- Accept at edge T. dm_req=1 with the LO write visible in cycle T+1.
- With dm_gnt tied high: LO written T+1, HI T+2, END T+3, done=1 from T+4.
- Each grant-low cycle adds one cycle of latency to the state it occurs in.
- A skipped write costs one cycle with no request.
- rst asserted in any state returns the FSM to IDLE and clears snap, base, counter and outputs at that edge. No partial write is completed: dm_req is 0 in the cycle after the rst edge.

## Test plan
- Reset: hold rst 3 cycles, then release -> cycle_count 0,1,2…; finish_ready=1, dm_req=0, done=0.
- Basic finish: dm_gnt=1, finish_count=5, accept when cycle_count=100 -> writes ('h2005, 100), ('h2006, 0), ('h3fff, FFFF_FFFF) on consecutive cycles; done=1 the cycle after; further finish_valid ignored.
- Grant stall: dm_gnt=0 for 3 cycles during WR_HI -> dm_addr/dm_wdata held at ('h2006, snap[63:32]); END write is delayed by exactly 3 cycles; no duplicate writes.
- Collision on LO: finish_count='h1fff -> no write to 'h3fff with snap; HI written to 'h0000; END written to 'h3fff; total 2 writes.
- Collision on HI: finish_count='h1ffe -> LO written to 'h3ffe, HI skipped, END written to 'h3fff.
- Reset mid-operation: assert rst while dm_req=1 in WR_HI with dm_gnt=0 -> dm_req=0 next cycle, done=0, cycle_count=0; a fresh finish then completes normally with its new snapshot.
